// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the control pipeline: mode codes, data-processing
// opcodes, EXE_CMD codes, condition codes, the decoded control-word struct with
// its field offsets, and the instruction decode function.
// Condition-code constants are used by cond_check, which the top instantiates
// only when CTRL_COND_EXEC_EN is defined.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // Instruction classes
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Execute-stage commands
  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_MOV  = 4'b0001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_ADC  = 4'b0011;
  localparam logic [3:0] CMD_SUB  = 4'b0100;
  localparam logic [3:0] CMD_SBC  = 4'b0101;
  localparam logic [3:0] CMD_AND  = 4'b0110;
  localparam logic [3:0] CMD_ORR  = 4'b0111;
  localparam logic [3:0] CMD_EOR  = 4'b1000;
  localparam logic [3:0] CMD_MVN  = 4'b1001;

  // Condition codes (flags are NZCV, N in bit 3)
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Decoded control word; the destination register travels beside it with
  // its own parameterised width.
  typedef struct packed {
    logic       wb;
    logic       mem_r;
    logic       mem_w;
    logic       set_flags;
    logic       is_branch;
    logic [3:0] cmd;
  } ctrl_word_t;

  // Bit offsets of the fields inside ctrl_word_t
  localparam int CW_CMD_LSB   = 0;
  localparam int CW_IS_BRANCH = 4;
  localparam int CW_SET_FLAGS = 5;
  localparam int CW_MEM_W     = 6;
  localparam int CW_MEM_R     = 7;
  localparam int CW_WB        = 8;

  // Unknown opcodes and mode 11 decode to an all-zero (NOP) word.
  function automatic ctrl_word_t decode(input logic [1:0] mode,
                                        input logic [3:0] opcode,
                                        input logic       s_bit);
    ctrl_word_t cw;
    cw = '0;
    case (mode)
      MODE_DP: begin
        cw.wb        = 1'b1;
        cw.set_flags = s_bit;
        case (opcode)
          OP_MOV:  cw.cmd = CMD_MOV;
          OP_MVN:  cw.cmd = CMD_MVN;
          OP_ADD:  cw.cmd = CMD_ADD;
          OP_ADC:  cw.cmd = CMD_ADC;
          OP_SUB:  cw.cmd = CMD_SUB;
          OP_SBC:  cw.cmd = CMD_SBC;
          OP_AND:  cw.cmd = CMD_AND;
          OP_ORR:  cw.cmd = CMD_ORR;
          OP_EOR:  cw.cmd = CMD_EOR;
          // Compare/test only exist to produce flags
          OP_CMP: begin
            cw.cmd       = CMD_SUB;
            cw.wb        = 1'b0;
            cw.set_flags = 1'b1;
          end
          OP_TST: begin
            cw.cmd       = CMD_AND;
            cw.wb        = 1'b0;
            cw.set_flags = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      MODE_MEM: begin
        cw.cmd = CMD_ADD;
        if (s_bit) begin
          cw.wb    = 1'b1;
          cw.mem_r = 1'b1;
        end else begin
          cw.mem_w = 1'b1;
        end
      end
      MODE_BR:  cw.is_branch = 1'b1;
      default:  cw = '0;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit_if
// Bundles the instruction-side inputs and the staged control outputs of
// ctrl_pipe_unit.
//   master : instruction source / hazard unit / ALU flags; observes controls
//   slave  : ctrl_pipe_unit itself
// ---------------------------------------------------------------------------
interface ctrl_pipe_unit_if #(
  parameter int CMD_W  = 4,
  parameter int REG_AW = 4
);
  // Instruction side
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [3:0]        opcode;
  logic              s_bit;
  logic [3:0]        cond;
  logic [REG_AW-1:0] dst;
  logic              hazard;
  logic [3:0]        ex_flags;
  // ID/EX stage
  logic              ex_valid;
  logic [CMD_W-1:0]  ex_cmd;
  logic              ex_wb_en;
  logic              ex_mem_r_en;
  logic              ex_mem_w_en;
  logic              ex_set_flags;
  logic [REG_AW-1:0] ex_dst;
  logic              branch_taken;
  // EX/MEM stage
  logic              mem_valid;
  logic              mem_wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [REG_AW-1:0] mem_dst;
  // MEM/WB stage
  logic              wb_valid;
  logic              wb_en;
  logic [REG_AW-1:0] wb_dst;
  logic [3:0]        status;

  modport master (
    output in_valid, mode, opcode, s_bit, cond, dst, hazard, ex_flags,
    input  in_ready, ex_valid, ex_cmd, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
           ex_set_flags, ex_dst, branch_taken, mem_valid, mem_wb_en,
           mem_r_en, mem_w_en, mem_dst, wb_valid, wb_en, wb_dst, status
  );

  modport slave (
    input  in_valid, mode, opcode, s_bit, cond, dst, hazard, ex_flags,
    output in_ready, ex_valid, ex_cmd, ex_wb_en, ex_mem_r_en, ex_mem_w_en,
           ex_set_flags, ex_dst, branch_taken, mem_valid, mem_wb_en,
           mem_r_en, mem_w_en, mem_dst, wb_valid, wb_en, wb_dst, status
  );
endinterface

// File: rtl/cond_check.sv
// ---------------------------------------------------------------------------
// cond_check
// Combinational ARM condition evaluation.
//   i_cond : condition field
//   i_nzcv : flags to test (N bit 3, Z bit 2, C bit 1, V bit 0)
//   o_pass : 1 when the instruction may execute
// AL and 1111 always pass.
// ---------------------------------------------------------------------------
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  assign w_n = i_nzcv[3];
  assign w_z = i_nzcv[2];
  assign w_c = i_nzcv[1];
  assign w_v = i_nzcv[0];

  // Condition decode
  always_comb begin
    o_pass = 1'b1;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit
// Decodes mode/opcode/S into execute, memory and writeback controls and
// carries them through ID/EX, EX/MEM and MEM/WB registers. Owns the hazard
// stall, the branch-shadow squash and (optionally) the NZCV status register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ctrl_pipe_unit_if.slave (instruction fields, hazard, ALU flags in;
//           in_ready, branch_taken, ex_*/mem_*/wb_* controls, status out)
// Parameters: CMD_W, REG_AW, SHADOW (instructions squashed after a taken
// branch, 0..7).
// Configuration macro CTRL_COND_EXEC_EN: when defined, instructions are
// predicated on their condition field against bypassed NZCV flags and a status
// register is kept; when undefined, cond is ignored and status reads 0.
// ---------------------------------------------------------------------------
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int REG_AW = 4,
  parameter int SHADOW = 1
)(
  input logic           clk,
  input logic           rst_n,
  ctrl_pipe_unit_if.slave bus
);

  localparam logic [2:0] SHADOW_LD = 3'(SHADOW);

  ctrl_word_t        w_dec;
  logic              w_accept;
  logic              w_cond_pass;
  logic              w_issue;
  logic              w_branch_taken;
  logic [2:0]        w_shadow_eff;
  logic [2:0]        w_shadow_nxt;
  logic [2:0]        r_shadow;
  logic [3:0]        w_status;

  logic              r_ex_valid, r_ex_wb, r_ex_mr, r_ex_mw, r_ex_sf, r_ex_br;
  logic [CMD_W-1:0]  r_ex_cmd;
  logic [REG_AW-1:0] r_ex_dst;
  logic              r_mem_valid, r_mem_wb, r_mem_mr, r_mem_mw;
  logic [REG_AW-1:0] r_mem_dst;
  logic              r_wb_valid, r_wb_en;
  logic [REG_AW-1:0] r_wb_dst;

  assign w_dec          = decode(bus.mode, bus.opcode, bus.s_bit);
  assign w_accept       = bus.in_valid && !bus.hazard;
  assign w_branch_taken = r_ex_valid && r_ex_br;

  // A branch resolving this cycle already shadows the instruction being
  // accepted now, so the reload value is used before it is registered.
  always_comb begin
    w_shadow_eff = r_shadow;
    w_shadow_nxt = r_shadow;
    if (w_branch_taken) begin
      w_shadow_eff = SHADOW_LD;
    end else begin
      w_shadow_eff = r_shadow;
    end
    if (w_accept && (w_shadow_eff != 3'd0)) begin
      w_shadow_nxt = w_shadow_eff - 3'd1;
    end else begin
      w_shadow_nxt = w_shadow_eff;
    end
  end

  assign w_issue = w_accept && w_cond_pass && (w_shadow_eff == 3'd0);

`ifdef CTRL_COND_EXEC_EN
  logic [3:0] r_status;
  logic [3:0] w_flags;

  // Flags being produced in EX are newer than the status register
  assign w_flags = (r_ex_valid && r_ex_sf) ? bus.ex_flags : r_status;

  cond_check u_cond_check (
    .i_cond (bus.cond),
    .i_nzcv (w_flags),
    .o_pass (w_cond_pass)
  );

  // NZCV status register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
    end else if (r_ex_valid && r_ex_sf) begin
      r_status <= bus.ex_flags;
    end
  end

  assign w_status = r_status;
`else
  logic w_unused_cond;
  assign w_unused_cond = ^{bus.cond, bus.ex_flags};
  assign w_cond_pass   = 1'b1;
  assign w_status      = 4'b0000;
`endif

  // Branch-shadow counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 3'd0;
    end else begin
      r_shadow <= w_shadow_nxt;
    end
  end

  // ID/EX register: loads the decoded word or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_cmd   <= '0;
      r_ex_wb    <= 1'b0;
      r_ex_mr    <= 1'b0;
      r_ex_mw    <= 1'b0;
      r_ex_sf    <= 1'b0;
      r_ex_br    <= 1'b0;
      r_ex_dst   <= '0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_cmd   <= CMD_W'(w_dec.cmd);
      r_ex_wb    <= w_dec.wb;
      r_ex_mr    <= w_dec.mem_r;
      r_ex_mw    <= w_dec.mem_w;
      r_ex_sf    <= w_dec.set_flags;
      r_ex_br    <= w_dec.is_branch;
      r_ex_dst   <= bus.dst;
    end else begin
      r_ex_valid <= 1'b0;
      r_ex_cmd   <= '0;
      r_ex_wb    <= 1'b0;
      r_ex_mr    <= 1'b0;
      r_ex_mw    <= 1'b0;
      r_ex_sf    <= 1'b0;
      r_ex_br    <= 1'b0;
      r_ex_dst   <= '0;
    end
  end

  // EX/MEM and MEM/WB registers advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid <= 1'b0;
      r_mem_wb    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_mem_mw    <= 1'b0;
      r_mem_dst   <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_dst    <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_wb    <= r_ex_wb;
      r_mem_mr    <= r_ex_mr;
      r_mem_mw    <= r_ex_mw;
      r_mem_dst   <= r_ex_dst;
      r_wb_valid  <= r_mem_valid;
      r_wb_en     <= r_mem_wb;
      r_wb_dst    <= r_mem_dst;
    end
  end

  assign bus.in_ready     = !bus.hazard;
  assign bus.branch_taken = w_branch_taken;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_cmd       = r_ex_cmd;
  assign bus.ex_wb_en     = r_ex_wb;
  assign bus.ex_mem_r_en  = r_ex_mr;
  assign bus.ex_mem_w_en  = r_ex_mw;
  assign bus.ex_set_flags = r_ex_sf;
  assign bus.ex_dst       = r_ex_dst;
  assign bus.mem_valid    = r_mem_valid;
  assign bus.mem_wb_en    = r_mem_wb;
  assign bus.mem_r_en     = r_mem_mr;
  assign bus.mem_w_en     = r_mem_mw;
  assign bus.mem_dst      = r_mem_dst;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_en        = r_wb_en;
  assign bus.wb_dst       = r_wb_dst;
  assign bus.status       = w_status;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_unit
// Self-checking bench for ctrl_pipe_unit: a decode vector table, hand-written
// multi-cycle sequences (latency, bypass, branch shadow, hazard stall, reset)
// and randomized stimulus compared against a behavioural reference model.
// Works with or without CTRL_COND_EXEC_EN.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_unit;

  localparam int SHADOW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_unit_if #(.CMD_W(4), .REG_AW(4)) bus ();

  ctrl_pipe_unit #(.CMD_W(4), .REG_AW(4), .SHADOW(SHADOW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic [3:0] c, input logic [3:0] d,
                       input logic hz);
    bus.in_valid = v; bus.mode = m; bus.opcode = op; bus.s_bit = s;
    bus.cond = c; bus.dst = d; bus.hazard = hz;
  endtask

  task automatic idle();
    drive(1'b0, 2'b11, 4'b0000, 1'b0, 4'b1110, 4'b0000, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic v; logic [3:0] cmd; logic wb, mr, mw, sf, br; logic [3:0] dst;
  } st_t;

  st_t        m_ex, m_mem, m_wb;
  logic [3:0] m_status;
  int         m_squash;

  logic [3:0] dp_op  [11] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
                              4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
  logic [3:0] dp_cmd [11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                              4'b0110, 4'b0111, 4'b1000, 4'b0100, 4'b0110};
  logic       dp_cmp [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic st_t model_decode(input logic [1:0] m, input logic [3:0] op,
                                       input logic s, input logic [3:0] d);
    st_t r;
    r = '0; r.v = 1'b1; r.dst = d;
    if (m == 2'b10) r.br = 1'b1;
    else if (m == 2'b01) begin
      r.cmd = 4'b0010;
      if (s) begin r.wb = 1'b1; r.mr = 1'b1; end
      else r.mw = 1'b1;
    end else if (m == 2'b00) begin
      for (int k = 0; k < 11; k++)
        if (dp_op[k] == op) begin
          r.cmd = dp_cmd[k]; r.wb = !dp_cmp[k]; r.sf = dp_cmp[k] | s;
        end
    end
    return r;
  endfunction

  // Even codes test a predicate, odd codes its complement; 111x always runs.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & !z;
      3'd5: base = (n == v);
      3'd6: base = !z & (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_status = 4'b0000; m_squash = 0;
  endtask

  task automatic model_step();
    st_t nx;
    logic [3:0] f;
    logic pass, acc;
    int sq;
    f = 4'b0000;
    pass = 1'b1;
`ifdef CTRL_COND_EXEC_EN
    f = (m_ex.v && m_ex.sf) ? bus.ex_flags : m_status;
    pass = model_cond(bus.cond, f);
`endif
    sq  = (m_ex.v && m_ex.br) ? SHADOW : m_squash;
    acc = bus.in_valid && !bus.hazard;
    nx  = '0;
    if (acc && pass && sq == 0) nx = model_decode(bus.mode, bus.opcode, bus.s_bit, bus.dst);
    if (acc && sq > 0) sq--;
    m_squash = sq;
`ifdef CTRL_COND_EXEC_EN
    if (m_ex.v && m_ex.sf) m_status = bus.ex_flags;
`endif
    m_wb = m_mem; m_mem = m_ex; m_ex = nx;
  endtask

  // Destination is compared only where it will be written back.
  function automatic logic [32:0] model_outs(input logic hz);
    return {!hz, m_ex.v && m_ex.br,
            m_ex.v, m_ex.cmd, m_ex.wb, m_ex.mr, m_ex.mw, m_ex.sf, m_ex.wb ? m_ex.dst : 4'b0000,
            m_mem.v, m_mem.wb, m_mem.mr, m_mem.mw, m_mem.wb ? m_mem.dst : 4'b0000,
            m_wb.v, m_wb.wb, m_wb.wb ? m_wb.dst : 4'b0000, m_status};
  endfunction

  function automatic logic [32:0] dut_outs();
    return {bus.in_ready, bus.branch_taken,
            bus.ex_valid, bus.ex_cmd, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en,
            bus.ex_set_flags, bus.ex_wb_en ? bus.ex_dst : 4'b0000,
            bus.mem_valid, bus.mem_wb_en, bus.mem_r_en, bus.mem_w_en,
            bus.mem_wb_en ? bus.mem_dst : 4'b0000,
            bus.wb_valid, bus.wb_en, bus.wb_en ? bus.wb_dst : 4'b0000, bus.status};
  endfunction

  task automatic do_reset();
    idle();
    @(negedge clk); rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [1:0] mode; logic [3:0] op; logic s;
    logic [3:0] cmd; logic wb, mr, mw, sf, br;
  } vec_t;

  vec_t vt[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{2'b00, 4'b1101, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // MOV
    vt[1]  = '{2'b00, 4'b1111, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // MVNS
    vt[2]  = '{2'b00, 4'b0100, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // ADD
    vt[3]  = '{2'b00, 4'b0101, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // ADCS
    vt[4]  = '{2'b00, 4'b0010, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // SUB
    vt[5]  = '{2'b00, 4'b0110, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // SBC
    vt[6]  = '{2'b00, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // AND
    vt[7]  = '{2'b00, 4'b1100, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // ORRS
    vt[8]  = '{2'b00, 4'b0001, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // EOR
    vt[9]  = '{2'b00, 4'b1010, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // CMP
    vt[10] = '{2'b00, 4'b1000, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // TST
    vt[11] = '{2'b00, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // unknown
    vt[12] = '{2'b01, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // LDR
    vt[13] = '{2'b01, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // STR
    vt[14] = '{2'b11, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // NOP
    vt[15] = '{2'b10, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // B

    bus.ex_flags = 4'b0000;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {31'b0, dut_outs()}, 64'd0 | {63'b0, 1'b1} << 32);
    rst_n = 1'b1;
    tick();

    // Decode table, one instruction per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].mode, vt[i].op, vt[i].s, 4'b1110, 4'(i), 1'b0);
      tick();
      check($sformatf("decode_%0d", i),
            {bus.ex_valid, bus.ex_cmd, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en,
             bus.ex_set_flags, bus.branch_taken},
            {1'b1, vt[i].cmd, vt[i].wb, vt[i].mr, vt[i].mw, vt[i].sf, vt[i].br});
    end

    // ADD latency through the three stages
    do_reset();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110, 4'd3, 1'b0);
    tick();
    idle();
    check("add_ex", {bus.ex_valid, bus.ex_cmd, bus.ex_wb_en, bus.ex_dst}, {1'b1, 4'b0010, 1'b1, 4'd3});
    tick();
    check("add_mem", {bus.ex_valid, bus.mem_valid, bus.mem_wb_en, bus.mem_dst}, {1'b0, 1'b1, 1'b1, 4'd3});
    tick();
    check("add_wb", {bus.mem_valid, bus.wb_valid, bus.wb_en, bus.wb_dst}, {1'b0, 1'b1, 1'b1, 4'd3});

    // Taken branch squashes exactly one following instruction
    do_reset();
    drive(1'b1, 2'b10, 4'b0000, 1'b0, 4'b1110, 4'd0, 1'b0);
    tick();
    check("br_taken", bus.branch_taken, 1'b1);
    drive(1'b1, 2'b00, 4'b0010, 1'b0, 4'b1110, 4'd5, 1'b0);
    #1 check("br_shadow_ready", bus.in_ready, 1'b1);
    tick();
    check("br_squash", {bus.ex_valid, bus.branch_taken}, 2'b00);
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110, 4'd6, 1'b0);
    tick();
    idle();
    check("br_after", {bus.ex_valid, bus.ex_cmd, bus.ex_dst}, {1'b1, 4'b0010, 4'd6});

    // LDR held off by a two-cycle hazard
    do_reset();
    drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110, 4'd2, 1'b0);
    tick();
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 4'b1110, 4'd7, 1'b1);
    #1 check("hz_ready", bus.in_ready, 1'b0);
    tick();
    check("hz_bubble1", {bus.ex_valid, bus.mem_valid}, 2'b01);
    tick();
    check("hz_bubble2", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b001);
    bus.hazard = 1'b0;
    #1 check("hz_release_ready", bus.in_ready, 1'b1);
    tick();
    idle();
    check("hz_ldr", {bus.ex_valid, bus.ex_wb_en, bus.ex_mem_r_en, bus.ex_mem_w_en, bus.ex_cmd},
          {4'b1110, 4'b0010});

`ifdef CTRL_COND_EXEC_EN
    // CMP result bypassed into the next instruction's condition
    do_reset();
    drive(1'b1, 2'b00, 4'b1010, 1'b1, 4'b1110, 4'd0, 1'b0);
    tick();
    bus.ex_flags = 4'b0100;
    drive(1'b1, 2'b00, 4'b1101, 1'b0, 4'b0000, 4'd1, 1'b0);
    tick();
    bus.ex_flags = 4'b0000;
    check("bypass_moveq", {bus.ex_valid, bus.status}, {1'b1, 4'b0100});
    drive(1'b1, 2'b00, 4'b1101, 1'b0, 4'b0001, 4'd1, 1'b0);
    tick();
    idle();
    check("bypass_movne", {bus.ex_valid, bus.status}, {1'b0, 4'b0100});
`else
    // Condition ignored and no status register
    do_reset();
    drive(1'b1, 2'b00, 4'b1101, 1'b0, 4'b0000, 4'd1, 1'b0);
    tick();
    check("nocond_moveq", bus.ex_valid, 1'b1);
    drive(1'b1, 2'b00, 4'b1010, 1'b1, 4'b0001, 4'd0, 1'b0);
    tick();
    idle();
    bus.ex_flags = 4'b1111;
    tick();
    bus.ex_flags = 4'b0000;
    check("nocond_status", bus.status, 4'b0000);
`endif

    // Asynchronous reset with the pipeline full
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 4'b0100, 1'b0, 4'b1110, 4'd9, 1'b0);
      tick();
    end
    drive(1'b0, 2'b11, 4'b0000, 1'b0, 4'b1110, 4'd0, 1'b1);
    check("full_before_rst", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b111);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {31'b0, dut_outs()}, 64'd0);
    #2 rst_n = 1'b1;
    model_reset();
    idle();
    tick();

    // Randomized run against the reference model
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive(1'($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b1110,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 2));
      bus.ex_flags = 4'($urandom_range(0, 15));
      @(negedge clk);
      check($sformatf("random_c%0d", cyc), {31'b0, dut_outs()}, {31'b0, model_outs(bus.hazard)});
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
